// File: rtl/issue_scoreboard.sv
// Issue-stage RAW/WAW hazard scoreboard with per-register pending-write counters.
// Optional macro SCB_WB_BYPASS_EN lets same-cycle writebacks release hazards and capacity.
module issue_scoreboard #(
  parameter int unsigned PEND_W       = 2,
  parameter int unsigned MAX_INFLIGHT = 4,
  parameter int unsigned STALL_CNT_W  = 32
) (
  input  logic                              CLK,
  input  logic                              RST_N,
  input  logic                              flush,
  input  logic                              dec_valid,
  output logic                              dec_ready,
  input  logic [4:0]                        dec_rs1,
  input  logic                              dec_use_rs1,
  input  logic [4:0]                        dec_rs2,
  input  logic                              dec_use_rs2,
  input  logic [4:0]                        dec_rd,
  input  logic                              dec_we,
  output logic                              issue_fire,
  input  logic                              wb_valid,
  input  logic [4:0]                        wb_rd,
  output logic [31:0]                       busy_mask,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight_cnt,
  output logic [STALL_CNT_W-1:0]            stall_cnt,
  output logic                              wb_err
);

  localparam int unsigned IF_W = $clog2(MAX_INFLIGHT + 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [PEND_W-1:0]      r_pend [32];
  logic [31:0]            r_busy_mask;
  logic [IF_W-1:0]        r_inflight;
  logic [STALL_CNT_W-1:0] r_stall_cnt;
  logic                   r_wb_err;

  logic [PEND_W-1:0] w_pend_nxt [32];
  logic [31:0]       w_busy_nxt;
  logic [IF_W-1:0]   w_inflight_nxt;
  logic              w_alloc;
  logic              w_wb_dec;
  logic              w_wb_stray;
  logic              w_byp_rs1;
  logic              w_byp_rs2;
  logic              w_byp_rd;
  logic              w_byp_cap;
  logic [PEND_W-1:0] w_pend_rs1;
  logic [PEND_W-1:0] w_pend_rs2;
  logic [PEND_W-1:0] w_pend_rd;
  logic [IF_W-1:0]   w_inflight_eff;
  logic              w_raw;
  logic              w_waw;
  logic              w_cap;
  logic              w_inc;
  logic              w_stall;

  assign w_alloc    = dec_we & (dec_rd != 5'd0);
  assign w_wb_dec   = wb_valid & (wb_rd != 5'd0) & (r_pend[wb_rd] != '0);
  assign w_wb_stray = wb_valid & (wb_rd != 5'd0) & (r_pend[wb_rd] == '0);

`ifdef SCB_WB_BYPASS_EN
  // A retiring writeback is treated as already gone for this cycle's checks.
  assign w_byp_rs1 = w_wb_dec & (wb_rd == dec_rs1);
  assign w_byp_rs2 = w_wb_dec & (wb_rd == dec_rs2);
  assign w_byp_rd  = w_wb_dec & (wb_rd == dec_rd);
  assign w_byp_cap = w_wb_dec;
`else
  assign w_byp_rs1 = 1'b0;
  assign w_byp_rs2 = 1'b0;
  assign w_byp_rd  = 1'b0;
  assign w_byp_cap = 1'b0;
`endif

  assign w_pend_rs1     = r_pend[dec_rs1] - PEND_W'(w_byp_rs1);
  assign w_pend_rs2     = r_pend[dec_rs2] - PEND_W'(w_byp_rs2);
  assign w_pend_rd      = r_pend[dec_rd]  - PEND_W'(w_byp_rd);
  assign w_inflight_eff = r_inflight - IF_W'(w_byp_cap);

  assign w_raw = (dec_use_rs1 & (dec_rs1 != 5'd0) & (w_pend_rs1 != '0)) |
                 (dec_use_rs2 & (dec_rs2 != 5'd0) & (w_pend_rs2 != '0));
  assign w_waw = w_alloc & (w_pend_rd == PEND_MAX);
  assign w_cap = w_alloc & (w_inflight_eff == IF_W'(MAX_INFLIGHT));

  assign dec_ready  = ~flush & ~w_raw & ~w_waw & ~w_cap;
  assign issue_fire = dec_valid & dec_ready;
  assign w_inc      = issue_fire & w_alloc;
  assign w_stall    = dec_valid & ~dec_ready & ~flush;

  // Next tracking state; an alloc and a retire on the same register cancel out.
  always_comb begin
    w_pend_nxt     = r_pend;
    w_inflight_nxt = r_inflight;
    w_busy_nxt     = '0;
    if (flush) begin
      w_pend_nxt     = '{default: '0};
      w_inflight_nxt = '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        w_pend_nxt[i] = r_pend[i] + PEND_W'(w_inc && (dec_rd == 5'(i)))
                                  - PEND_W'(w_wb_dec && (wb_rd == 5'(i)));
      end
      w_inflight_nxt = r_inflight + IF_W'(w_inc) - IF_W'(w_wb_dec);
    end
    for (int i = 1; i < 32; i++) begin
      w_busy_nxt[i] = (w_pend_nxt[i] != '0);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pend      <= '{default: '0};
      r_busy_mask <= '0;
      r_inflight  <= '0;
      r_stall_cnt <= '0;
      r_wb_err    <= 1'b0;
    end else begin
      r_pend      <= w_pend_nxt;
      r_busy_mask <= w_busy_nxt;
      r_inflight  <= w_inflight_nxt;
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
      end
      if (!flush && w_wb_stray) begin
        r_wb_err <= 1'b1;
      end
    end
  end

  assign busy_mask    = r_busy_mask;
  assign inflight_cnt = r_inflight;
  assign stall_cnt    = r_stall_cnt;
  assign wb_err       = r_wb_err;

endmodule
